// File: rtl/resp_defs.sv
// Shared types and address-map constants for the CPU memory responder.
package resp_defs;

  typedef enum logic [1:0] {REG_WRAM, REG_PPU, REG_PRG, REG_OPEN} region_t;

  typedef enum logic [1:0] {DMA_IDLE, DMA_ALIGN, DMA_RD, DMA_WR} dma_state_t;

  localparam logic [15:0] WRAM_MIRROR_END = 16'h1FFF;
  localparam logic [15:0] PPU_END         = 16'h3FFF;
  localparam logic [15:0] PRG_BASE        = 16'h8000;

  function automatic region_t decode_region(input logic [15:0] addr);
    if (addr <= WRAM_MIRROR_END)   return REG_WRAM;
    else if (addr <= PPU_END)      return REG_PPU;
    else if (addr >= PRG_BASE)     return REG_PRG;
    else                           return REG_OPEN;
  endfunction

endpackage

// File: rtl/wram_sp.sv
// Single-port work RAM: synchronous write, write-first read port so a read
// at the address being written sees the new byte.
module wram_sp #(
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = we ? wdata : mem[addr];

endmodule

// File: rtl/cpu_mem_responder.sv
// CPU data-bus responder: WRAM / PPU window / PRG decode with one-cycle read
// latency, plus the $4014 OAM DMA engine (built only when OAM_DMA_EN is defined).
module cpu_mem_responder
  import resp_defs::*;
#(
  parameter int          WRAM_AW  = 11,
  parameter logic [7:0]  OPEN_BUS = 8'h00,
  parameter logic [15:0] DMA_PAGE = 16'h4014
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_we,
  input  logic        cpu_re,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_halt,
  output logic [2:0]  ppu_reg_sel,
  output logic [7:0]  ppu_wdata,
  output logic        ppu_we,
  output logic        ppu_re,
  input  logic [7:0]  ppu_rdata,
  output logic [14:0] prg_addr,
  input  logic [7:0]  prg_rdata,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_wdata,
  output logic        oam_we
);

  logic        halt;
  logic [15:0] bus_addr;
  region_t     region;
  logic [7:0]  rd_data;
  logic [7:0]  wram_rdata;
  logic        wram_we;

`ifdef OAM_DMA_EN
  dma_state_t state, state_nx;
  logic [7:0] page, idx, dma_data;
  logic       dma_rd;
  logic       trigger;

  assign trigger = cpu_we && (cpu_addr == DMA_PAGE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= DMA_IDLE;
    else      state <= state_nx;
  end

  // ALIGN is a dead cycle so the CPU's last strobe drains before DMA owns the bus
  always_comb begin
    state_nx = state;
    halt     = 1'b1;
    dma_rd   = 1'b0;
    oam_we   = 1'b0;
    case (state)
      DMA_IDLE: begin
        halt = 1'b0;
        if (trigger) state_nx = DMA_ALIGN;
      end
      DMA_ALIGN: state_nx = DMA_RD;
      DMA_RD: begin
        dma_rd   = 1'b1;
        state_nx = DMA_WR;
      end
      DMA_WR: begin
        oam_we   = 1'b1;
        state_nx = (idx == 8'hFF) ? DMA_IDLE : DMA_RD;
      end
      default: state_nx = DMA_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      page     <= 8'h00;
      idx      <= 8'h00;
      dma_data <= 8'h00;
    end else begin
      if (state == DMA_IDLE && trigger) begin
        page <= cpu_wdata;
        idx  <= 8'h00;
      end
      if (dma_rd)            dma_data <= rd_data;
      if (state == DMA_WR)   idx      <= idx + 8'd1;
    end
  end

  assign bus_addr  = dma_rd ? {page, idx} : cpu_addr;
  assign cpu_halt  = halt;
  assign oam_addr  = idx;
  assign oam_wdata = dma_data;
`else
  logic unused_dma_page;

  assign unused_dma_page = ^DMA_PAGE;
  assign halt      = 1'b0;
  assign bus_addr  = cpu_addr;
  assign cpu_halt  = 1'b0;
  assign oam_we    = 1'b0;
  assign oam_addr  = 8'h00;
  assign oam_wdata = 8'h00;
`endif

  assign region      = decode_region(bus_addr);
  assign ppu_reg_sel = bus_addr[2:0];
  assign prg_addr    = bus_addr[14:0];
  assign wram_we     = cpu_we && !halt && (region == REG_WRAM);

  wram_sp #(.AW(WRAM_AW)) u_wram (
    .clk   (clk),
    .we    (wram_we),
    .addr  (bus_addr[WRAM_AW-1:0]),
    .wdata (cpu_wdata),
    .rdata (wram_rdata)
  );

  always_comb begin
    rd_data = OPEN_BUS;
    case (region)
      REG_WRAM: rd_data = wram_rdata;
      REG_PPU:  rd_data = ppu_rdata;
      REG_PRG:  rd_data = prg_rdata;
      default:  rd_data = OPEN_BUS;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       cpu_rdata <= 8'h00;
    else if (!halt) cpu_rdata <= rd_data;
  end

  // A simultaneous write wins over the read, so its side-effect strobe is dropped
  assign ppu_wdata = cpu_wdata;
  assign ppu_we    = rst && cpu_we && !halt && (region == REG_PPU);
  assign ppu_re    = rst && cpu_re && !cpu_we && !halt && (region == REG_PPU);

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Scoreboard bench for cpu_mem_responder; DMA scenarios run when OAM_DMA_EN is defined.
module tb_cpu_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] cpu_addr = 16'h0;
  logic [7:0]  cpu_wdata = 8'h0;
  logic        cpu_we = 1'b0;
  logic        cpu_re = 1'b0;
  logic [7:0]  cpu_rdata;
  logic        cpu_halt;
  logic [2:0]  ppu_reg_sel;
  logic [7:0]  ppu_wdata;
  logic        ppu_we;
  logic        ppu_re;
  logic [7:0]  ppu_rdata;
  logic [14:0] prg_addr;
  logic [7:0]  prg_rdata;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_wdata;
  logic        oam_we;

  always #5 clk = ~clk;

  cpu_mem_responder dut (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_we(cpu_we), .cpu_re(cpu_re), .cpu_rdata(cpu_rdata), .cpu_halt(cpu_halt),
    .ppu_reg_sel(ppu_reg_sel), .ppu_wdata(ppu_wdata), .ppu_we(ppu_we), .ppu_re(ppu_re),
    .ppu_rdata(ppu_rdata), .prg_addr(prg_addr), .prg_rdata(prg_rdata),
    .oam_addr(oam_addr), .oam_wdata(oam_wdata), .oam_we(oam_we)
  );

  // Peripheral models
  assign ppu_rdata = 8'h50 ^ {5'b0, ppu_reg_sel};
  assign prg_rdata = prg_addr[7:0];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  typedef struct {
    string      name;
    logic [7:0] data;
  } rd_exp_t;

  rd_exp_t     rd_q[$];
  logic [15:0] oam_q[$];
  logic        rd_issue = 1'b0;
  logic        rd_p1 = 1'b0;
  int          oam_cnt = 0;
  int          ppu_re_cnt = 0;
  int          ppu_we_cnt = 0;
  rd_exp_t     rd_e;
  logic [15:0] oam_e;

  always @(posedge clk) rd_p1 <= rd_issue;

  // Monitor: pops the scoreboard whenever read data or an OAM write is presented
  always @(negedge clk) begin
    if (rd_p1) begin
      if (rd_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected: read data %0h with nothing expected", cpu_rdata);
      end else begin
        rd_e = rd_q.pop_front();
        check(rd_e.name, cpu_rdata, rd_e.data);
      end
    end
    if (oam_we) begin
      oam_cnt++;
      if (oam_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL oam_unexpected: write addr %0h data %0h, no write required", oam_addr, oam_wdata);
      end else begin
        oam_e = oam_q.pop_front();
        check("oam_addr", oam_addr, oam_e[15:8]);
        check("oam_wdata", oam_wdata, oam_e[7:0]);
      end
    end
    if (ppu_re) ppu_re_cnt++;
    if (ppu_we) ppu_we_cnt++;
  end

  task automatic bus_read(input logic [15:0] addr, input logic [7:0] exp,
                          input logic re, input string name);
    cpu_addr = addr;
    cpu_re   = re;
    cpu_we   = 1'b0;
    rd_issue = 1'b1;
    rd_q.push_back('{name, exp});
    @(posedge clk); #1;
    cpu_re   = 1'b0;
    rd_issue = 1'b0;
  endtask

  task automatic bus_write(input logic [15:0] addr, input logic [7:0] data);
    cpu_addr  = addr;
    cpu_wdata = data;
    cpu_we    = 1'b1;
    @(posedge clk); #1;
    cpu_we    = 1'b0;
  endtask

  task automatic bus_write_rd(input logic [15:0] addr, input logic [7:0] data, input string name);
    cpu_addr  = addr;
    cpu_wdata = data;
    cpu_we    = 1'b1;
    rd_issue  = 1'b1;
    rd_q.push_back('{name, data});
    @(posedge clk); #1;
    cpu_we    = 1'b0;
    rd_issue  = 1'b0;
  endtask

`ifdef OAM_DMA_EN
  task automatic push_dma_expect();
    for (int i = 0; i < 256; i++) oam_q.push_back({i[7:0], i[7:0] ^ 8'h3C});
  endtask

  // Counts halted cycles from the trigger write; pokes CPU strobes mid-DMA
  task automatic run_dma(input string name);
    int n;
    int o0;
    n  = 0;
    o0 = oam_cnt;
    push_dma_expect();
    bus_write(16'h4014, 8'h02);
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (cpu_halt) n++;
      else if (n > 0) break;
      if (n == 10) begin
        cpu_addr  = 16'h0005;
        cpu_wdata = 8'hEE;
        cpu_we    = 1'b1;
        cpu_re    = 1'b1;
      end
      if (n == 11) begin
        cpu_we = 1'b0;
        cpu_re = 1'b0;
        cpu_addr = 16'h2002;
      end
      if (n == 300) check({name, "_rdata_hold"}, cpu_rdata, 8'h00);
    end
    check({name, "_halt_cycles"}, n, 513);
    check({name, "_oam_count"}, oam_cnt - o0, 256);
    check({name, "_oam_q_drained"}, oam_q.size(), 0);
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    int c0;
    int w0;
    int o0;
    int h;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cpu_rdata", cpu_rdata, 8'h00);
    check("rst_cpu_halt", cpu_halt, 1'b0);
    check("rst_ppu_we", ppu_we, 1'b0);
    check("rst_ppu_re", ppu_re, 1'b0);
    check("rst_oam_we", oam_we, 1'b0);
    check("rst_oam_addr", oam_addr, 8'h00);
    check("rst_oam_wdata", oam_wdata, 8'h00);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // WRAM and mirroring
    bus_write(16'h0005, 8'hA5);
    bus_read(16'h0805, 8'hA5, 1'b0, "wram_mirror");
    bus_read(16'h1805, 8'hA5, 1'b0, "wram_mirror_hi");
    bus_write_rd(16'h0010, 8'h33, "wram_rdw");
    bus_read(16'h0010, 8'h33, 1'b0, "wram_readback");

    // PPU window
    c0 = ppu_re_cnt;
    cpu_addr = 16'h2002;
    cpu_re   = 1'b1;
    rd_issue = 1'b1;
    rd_q.push_back('{"ppu_read", 8'h52});
    @(negedge clk);
    check("ppu_reg_sel", ppu_reg_sel, 3'd2);
    check("ppu_re_level", ppu_re, 1'b1);
    @(posedge clk); #1;
    cpu_re   = 1'b0;
    rd_issue = 1'b0;
    bus_read(16'h2002, 8'h52, 1'b0, "ppu_read_plain");
    check("ppu_re_pulses", ppu_re_cnt - c0, 1);
    bus_read(16'h3FFF, 8'h57, 1'b0, "ppu_mirror");

    c0 = ppu_re_cnt;
    w0 = ppu_we_cnt;
    cpu_addr  = 16'h2005;
    cpu_wdata = 8'h9C;
    cpu_we    = 1'b1;
    cpu_re    = 1'b1;
    @(negedge clk);
    check("ppu_wdata", ppu_wdata, 8'h9C);
    check("ppu_we_sel", ppu_reg_sel, 3'd5);
    @(posedge clk); #1;
    cpu_we = 1'b0;
    cpu_re = 1'b0;
    check("ppu_re_suppressed", ppu_re_cnt - c0, 0);
    check("ppu_we_pulses", ppu_we_cnt - w0, 1);

    // PRG ROM and unmapped space
    bus_write(16'h0000, 8'h11);
    cpu_addr = 16'hFFFC;
    rd_issue = 1'b1;
    rd_q.push_back('{"prg_read", 8'hFC});
    @(negedge clk);
    check("prg_addr", prg_addr, 15'h7FFC);
    @(posedge clk); #1;
    rd_issue = 1'b0;
    bus_write(16'h8000, 8'h77);
    bus_read(16'h8000, 8'h00, 1'b0, "prg_after_write");
    bus_read(16'h0000, 8'h11, 1'b0, "wram_untouched_by_prg_write");
    bus_read(16'h5000, 8'h00, 1'b0, "open_bus");
    bus_read(16'h4014, 8'h00, 1'b0, "open_4014");

`ifdef OAM_DMA_EN
    for (int i = 0; i < 256; i++) bus_write(16'h0200 + 16'(i), 8'(i) ^ 8'h3C);
    run_dma("dma1");
    bus_read(16'h0005, 8'hA5, 1'b0, "halt_write_ignored");

    // Abort mid-transfer with asynchronous reset
    push_dma_expect();
    o0 = oam_cnt;
    bus_write(16'h4014, 8'h02);
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (oam_cnt - o0 >= 100) break;
    end
    check("dma_progress", oam_cnt - o0, 100);
    check("halt_before_abort", cpu_halt, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check("abort_halt", cpu_halt, 1'b0);
    check("abort_oam_we", oam_we, 1'b0);
    oam_q.delete();
    o0 = oam_cnt;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("abort_no_more_oam", oam_cnt - o0, 0);
    check("abort_oam_addr", oam_addr, 8'h00);
    run_dma("dma2");
`else
    o0 = oam_cnt;
    h  = 0;
    bus_write(16'h4014, 8'h5A);
    repeat (20) begin
      @(negedge clk);
      if (cpu_halt) h++;
    end
    @(posedge clk); #1;
    check("dis_halt", h, 0);
    check("dis_oam_we", oam_cnt - o0, 0);
    check("dis_oam_addr", oam_addr, 8'h00);
    bus_read(16'h4014, 8'h00, 1'b0, "dis_open_4014");
`endif

    repeat (3) @(posedge clk);
    check("rd_q_drained", rd_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
